op_mux: RTL and testbench



---
 rtl/op_mux_pkg.sv | 35 +++
 rtl/op_mux_if.sv | 32 +++
 rtl/op_fmt.sv | 58 +++++
 rtl/op_mux.sv | 142 ++++++++++++++
 tb/tb_op_mux.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/op_mux_pkg.sv
// Shared encodings and widths for the op_mux store path.
// Optional build macro OP_MUX_TIMEOUT_EN is consumed by op_mux.
package op_mux_pkg;

    localparam int PA_OP   = 3;
    localparam int PA_HL   = 2;
    localparam int PA_DATA = 32;
    localparam int PA_ADDR = 32;
    localparam int PA_TO   = 8;

    typedef enum logic [PA_OP-1:0] {
        SEL_NONE = 3'b000,
        SEL_RFA  = 3'b001,
        SEL_ALU  = 3'b010,
        SEL_RFB  = 3'b011,
        SEL_IMM  = 3'b100
    } op_sel_e;

    typedef enum logic [PA_HL-1:0] {
        HL_WORD = 2'b00,
        HL_LO   = 2'b01,
        HL_HI   = 2'b10
    } hl_sel_e;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_LO   = 4'b0011;
    localparam logic [3:0] BE_HI   = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/op_mux_if.sv
// Request/select/data bundle between the requester and op_mux, plus the memory-side write bus.
interface op_mux_if;
    import op_mux_pkg::*;

    logic                 req;
    logic [PA_OP-1:0]     op_sel;
    logic [PA_HL-1:0]     hl_sel;
    logic [PA_DATA-1:0]   rf_a;
    logic [PA_DATA-1:0]   rf_b;
    logic [PA_DATA-1:0]   alu_out;
    logic [15:0]          id_imme;
    logic [PA_ADDR-1:0]   addr_in;
    logic                 dob_ack;
    logic [PA_DATA-1:0]   dob;
    logic [PA_ADDR-1:0]   dab;
    logic                 dob_we;
    logic [3:0]           dob_be;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport master (
        output req, op_sel, hl_sel, rf_a, rf_b, alu_out, id_imme, addr_in, dob_ack,
        input  dob, dab, dob_we, dob_be, busy, done, err
    );

    modport slave (
        input  req, op_sel, hl_sel, rf_a, rf_b, alu_out, id_imme, addr_in, dob_ack,
        output dob, dab, dob_we, dob_be, busy, done, err
    );

endinterface

// File: rtl/op_fmt.sv
// Combinational source select and half-word formatting with byte enables and illegal-select flag.
module op_fmt
    import op_mux_pkg::*;
(
    input  logic [PA_OP-1:0]   op_sel,
    input  logic [PA_HL-1:0]   hl_sel,
    input  logic [PA_DATA-1:0] rf_a,
    input  logic [PA_DATA-1:0] rf_b,
    input  logic [PA_DATA-1:0] alu_out,
    input  logic [15:0]        id_imme,
    output logic [PA_DATA-1:0] fmt_data,
    output logic [3:0]         fmt_be,
    output logic               fmt_illegal
);

    logic [PA_DATA-1:0] src_s;
    logic               op_bad_s;
    logic               hl_bad_s;

    // Source select; unlisted encodings flag the request as illegal.
    always_comb begin
        src_s    = {PA_DATA{1'b0}};
        op_bad_s = 1'b0;
        case (op_sel)
            SEL_RFA:  src_s = rf_a;
            SEL_ALU:  src_s = alu_out;
            SEL_RFB:  src_s = rf_b;
            SEL_IMM:  src_s = {16'h0000, id_imme};
            SEL_NONE: op_bad_s = 1'b1;
            default:  op_bad_s = 1'b1;
        endcase
    end

    // Half-word formats always take the low half of the source.
    always_comb begin
        fmt_data = src_s;
        fmt_be   = BE_WORD;
        hl_bad_s = 1'b0;
        case (hl_sel)
            HL_WORD: begin
                fmt_data = src_s;
                fmt_be   = BE_WORD;
            end
            HL_LO: begin
                fmt_data = {16'h0000, src_s[15:0]};
                fmt_be   = BE_LO;
            end
            HL_HI: begin
                fmt_data = {src_s[15:0], 16'h0000};
                fmt_be   = BE_HI;
            end
            default: hl_bad_s = 1'b1;
        endcase
    end

    assign fmt_illegal = op_bad_s | hl_bad_s;

endmodule

// File: rtl/op_mux.sv
// Store-side output mux: captures a formatted operand and drives it to memory with a req/ack write.
// Build option OP_MUX_TIMEOUT_EN adds a DRIVE-state timeout that aborts with an err pulse.
module op_mux
    import op_mux_pkg::*;
(
    input  logic       clk,
    input  logic       rst_b,
    op_mux_if.slave    bus
);

    logic [PA_DATA-1:0] fmt_data_s;
    logic [3:0]         fmt_be_s;
    logic               fmt_illegal_s;

    op_fmt u_fmt (
        .op_sel      (bus.op_sel),
        .hl_sel      (bus.hl_sel),
        .rf_a        (bus.rf_a),
        .rf_b        (bus.rf_b),
        .alu_out     (bus.alu_out),
        .id_imme     (bus.id_imme),
        .fmt_data    (fmt_data_s),
        .fmt_be      (fmt_be_s),
        .fmt_illegal (fmt_illegal_s)
    );

    state_e             state_q, state_d;
    logic [PA_DATA-1:0] dob_q, dob_d;
    logic [PA_ADDR-1:0] dab_q, dab_d;
    logic [3:0]         be_q, be_d;
    logic               we_q, we_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
`ifdef OP_MUX_TIMEOUT_EN
    logic [PA_TO-1:0]   cnt_q, cnt_d;
`endif

    // Next-state and next-output computation; pulses default low, bus fields hold.
    always_comb begin
        state_d = state_q;
        dob_d   = dob_q;
        dab_d   = dab_q;
        be_d    = be_q;
        we_d    = we_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef OP_MUX_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    if (fmt_illegal_s) begin
                        err_d = 1'b1;
                    end else begin
                        dob_d   = fmt_data_s;
                        dab_d   = bus.addr_in;
                        be_d    = fmt_be_s;
                        we_d    = 1'b1;
                        busy_d  = 1'b1;
                        state_d = ST_DRIVE;
`ifdef OP_MUX_TIMEOUT_EN
                        cnt_d   = {PA_TO{1'b0}};
`endif
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (bus.dob_ack) begin
                    we_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
`ifdef OP_MUX_TIMEOUT_EN
                    // An ack in the expiry cycle is taken by the branch above.
                    if (cnt_q == {PA_TO{1'b1}}) begin
                        we_d    = 1'b0;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + {{(PA_TO-1){1'b0}}, 1'b1};
                    end
`else
                    state_d = ST_DRIVE;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                we_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; async reset clears every output immediately.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            dob_q   <= {PA_DATA{1'b0}};
            dab_q   <= {PA_ADDR{1'b0}};
            be_q    <= 4'b0000;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef OP_MUX_TIMEOUT_EN
            cnt_q   <= {PA_TO{1'b0}};
`endif
        end else begin
            state_q <= state_d;
            dob_q   <= dob_d;
            dab_q   <= dab_d;
            be_q    <= be_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef OP_MUX_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.dob    = dob_q;
    assign bus.dab    = dab_q;
    assign bus.dob_be = be_q;
    assign bus.dob_we = we_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_op_mux.sv
// Self-checking bench for op_mux: per-cycle expectation timeline built from transaction plans.
module tb_op_mux;
    import op_mux_pkg::*;

    localparam int MAXC = 2048;
    localparam int TO_CYC = 1 << PA_TO;

    logic clk;
    logic rst_b;
    int   cyc;
    int   n_tests;
    int   n_fail;
    int   done_cnt;

    op_mux_if bus ();

    op_mux dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    bit [31:0] exp_dob  [MAXC];
    bit [31:0] exp_dab  [MAXC];
    bit [3:0]  exp_be   [MAXC];
    bit        exp_we   [MAXC];
    bit        exp_busy [MAXC];
    bit        exp_done [MAXC];
    bit        exp_err  [MAXC];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    // Specification-level view of source selection and formatting.
    function automatic bit model_fmt(input logic [2:0] op, input logic [1:0] hl,
                                     input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] alu, input logic [15:0] imm,
                                     output bit [31:0] data, output bit [3:0] be);
        bit [31:0] src;
        data = 32'h0;
        be   = 4'h0;
        if (op == 3'd1)      src = a;
        else if (op == 3'd2) src = alu;
        else if (op == 3'd3) src = b;
        else if (op == 3'd4) src = {16'h0, imm};
        else                 return 1'b0;
        if (hl == 2'd0)      begin data = src;                         be = 4'b1111; end
        else if (hl == 2'd1) begin data = src & 32'h0000FFFF;          be = 4'b0011; end
        else if (hl == 2'd2) begin data = (src & 32'h0000FFFF) << 16;  be = 4'b1100; end
        else                 return 1'b0;
        return 1'b1;
    endfunction

    // Every cycle, outputs must match the planned timeline.
    always @(negedge clk) begin
        if (cyc < MAXC) begin
            chk("dob",  bus.dob,    exp_dob[cyc]);
            chk("dab",  bus.dab,    exp_dab[cyc]);
            chk("be",   {28'h0, bus.dob_be}, {28'h0, exp_be[cyc]});
            chk("we",   {31'h0, bus.dob_we}, {31'h0, exp_we[cyc]});
            chk("busy", {31'h0, bus.busy},   {31'h0, exp_busy[cyc]});
            chk("done", {31'h0, bus.done},   {31'h0, exp_done[cyc]});
            chk("err",  {31'h0, bus.err},    {31'h0, exp_err[cyc]});
            if (bus.done === 1'b1) done_cnt++;
        end
    end

    // Issue a one-cycle req at cycle n and record what the outputs must do.
    task automatic start(input logic [2:0] op, input logic [1:0] hl, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] alu, input logic [15:0] imm,
                         input logic [31:0] addr, input int ack_dly, output int n);
        bit [31:0] d;
        bit [3:0]  be;
        bit        legal;
        int        last;
        @(posedge clk); #1;
        n = cyc;
        bus.op_sel = op; bus.hl_sel = hl; bus.rf_a = a; bus.rf_b = b;
        bus.alu_out = alu; bus.id_imme = imm; bus.addr_in = addr; bus.req = 1'b1;
        legal = model_fmt(op, hl, a, b, alu, imm, d, be);
        if (!legal) begin
            exp_err[n+1] = 1'b1;
        end else begin
            for (int c = n + 1; c < MAXC; c++) begin
                exp_dob[c] = d; exp_dab[c] = addr; exp_be[c] = be;
            end
            if (ack_dly >= 0) begin
                last = n + ack_dly;
                exp_done[last+1] = 1'b1;
            end else begin
`ifdef OP_MUX_TIMEOUT_EN
                last = n + TO_CYC;
                exp_err[last+1] = 1'b1;
`else
                last = MAXC - 1;
`endif
            end
            for (int c = n + 1; c <= last && c < MAXC; c++) begin
                exp_we[c] = 1'b1; exp_busy[c] = 1'b1;
            end
        end
        @(posedge clk); #1;
        bus.req = 1'b0;
    endtask

    // Drive ack in cycle n+ack_dly; optionally poke ignored reqs in DRIVE and DONE.
    task automatic finish(input int n, input int ack_dly, input bit extra);
        for (int c = n + 1; c <= n + ack_dly; c++) begin
            bus.req = extra && (c == n + 2);
            if (extra && c == n + 2) bus.op_sel = 3'b000;
            bus.dob_ack = (c == n + ack_dly);
            @(posedge clk); #1;
        end
        bus.req = 1'b0;
        bus.dob_ack = 1'b0;
        if (extra) begin
            bus.op_sel = 3'b001; bus.hl_sel = 2'b00; bus.req = 1'b1;
            @(posedge clk); #1;
            bus.req = 1'b0;
        end
    endtask

    initial begin
        int n;
        int dc;
        int r;
        n_tests = 0; n_fail = 0; done_cnt = 0; cyc = 0;
        rst_b = 1'b0;
        bus.req = 1'b0; bus.op_sel = 3'b000; bus.hl_sel = 2'b00; bus.rf_a = 32'h0;
        bus.rf_b = 32'h0; bus.alu_out = 32'h0; bus.id_imme = 16'h0; bus.addr_in = 32'h0;
        bus.dob_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", {31'h0, bus.dob_we}, 32'h0);
        chk("rst_dob", bus.dob, 32'h0);
        rst_b = 1'b1;

        // Word store, ack in N+3.
        start(3'b001, 2'b00, 32'hDEADBEEF, 32'h11111111, 32'h22222222, 16'h3333, 32'h100, 3, n);
        finish(n, 3, 1'b0);
        chk("t1_done", {31'h0, bus.done}, 32'h1);
        chk("t1_dob", bus.dob, 32'hDEADBEEF);
        chk("t1_dab", bus.dab, 32'h100);
        chk("t1_be", {28'h0, bus.dob_be}, 32'hF);
        repeat (2) @(posedge clk);
        #1;

        // Upper-half immediate with immediate ack.
        start(3'b100, 2'b10, 32'h0, 32'h0, 32'h0, 16'h1234, 32'h204, 1, n);
        finish(n, 1, 1'b0);
        chk("t2_done", {31'h0, bus.done}, 32'h1);
        chk("t2_dob", bus.dob, 32'h12340000);
        chk("t2_be", {28'h0, bus.dob_be}, 32'hC);
        repeat (2) @(posedge clk);
        #1;

        // Lower-half ALU with reqs poked during DRIVE and DONE.
        dc = done_cnt;
        start(3'b010, 2'b01, 32'h0, 32'h0, 32'hAAAA5555, 16'h0, 32'h308, 3, n);
        finish(n, 3, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_dob", bus.dob, 32'h00005555);
        chk("t3_done_count", done_cnt - dc, 32'd1);

        // Rf_b word store plus ack while idle (must be ignored).
        start(3'b011, 2'b00, 32'h0, 32'hCAFEF00D, 32'h0, 16'h0, 32'h40C, 2, n);
        finish(n, 2, 1'b0);
        @(posedge clk); #1;
        bus.dob_ack = 1'b1;
        @(posedge clk); #1;
        bus.dob_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Illegal selects.
        start(3'b000, 2'b00, 32'h5, 32'h6, 32'h7, 16'h8, 32'h500, 1, n);
        chk("t4a_err", {31'h0, bus.err}, 32'h1);
        chk("t4a_we", {31'h0, bus.dob_we}, 32'h0);
        start(3'b001, 2'b11, 32'h5, 32'h6, 32'h7, 16'h8, 32'h504, 1, n);
        chk("t4b_err", {31'h0, bus.err}, 32'h1);
        chk("t4b_busy", {31'h0, bus.busy}, 32'h0);
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of DRIVE.
        start(3'b001, 2'b00, 32'h87654321, 32'h0, 32'h0, 16'h0, 32'h600, -1, n);
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        rst_b = 1'b0;
        r = cyc;
        #1;
        chk("t5_we", {31'h0, bus.dob_we}, 32'h0);
        chk("t5_busy", {31'h0, bus.busy}, 32'h0);
        chk("t5_dob", bus.dob, 32'h0);
        for (int c = r + 1; c < MAXC; c++) begin
            exp_dob[c] = 32'h0; exp_dab[c] = 32'h0; exp_be[c] = 4'h0;
            exp_we[c] = 1'b0; exp_busy[c] = 1'b0; exp_done[c] = 1'b0; exp_err[c] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;
        start(3'b001, 2'b00, 32'h0BADC0DE, 32'h0, 32'h0, 16'h0, 32'h700, 2, n);
        finish(n, 2, 1'b0);
        chk("t5_fresh_done", {31'h0, bus.done}, 32'h1);
        chk("t5_fresh_dob", bus.dob, 32'h0BADC0DE);
        repeat (2) @(posedge clk);
        #1;

        // Store without ack: timeout abort when enabled, otherwise waits forever.
        start(3'b011, 2'b01, 32'h0, 32'h9999ABCD, 32'h0, 16'h0, 32'h800, -1, n);
`ifdef OP_MUX_TIMEOUT_EN
        repeat (TO_CYC + 4) @(posedge clk);
        #1;
        chk("t6_we_after_to", {31'h0, bus.dob_we}, 32'h0);
        chk("t6_busy_after_to", {31'h0, bus.busy}, 32'h0);
`else
        repeat (100) @(posedge clk);
        #1;
        chk("t6_we_held", {31'h0, bus.dob_we}, 32'h1);
        chk("t6_dob_held", bus.dob, 32'h0000ABCD);
`endif
        @(negedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
